ibuf_bank_seq: RTL

IBUF_BANK_SEQ -- requirements
Module: ibuf_bank_seq

---
 rtl/ibuf_bank_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/ibuf_bank_seq.sv
// ibuf_bank_seq: staggered power-up sequencer for an I_BUF bank with synchronized, gated data
module ibuf_bank_seq #(
  parameter int WIDTH          = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE_REQ,
  output logic [WIDTH-1:0] BUF_EN,
  input  logic [WIDTH-1:0] BUF_O,
  output logic [WIDTH-1:0] DATA,
  output logic             READY,
  output logic             BUSY
);
  localparam int MAXC = (STAGGER_CYCLES > SETTLE_CYCLES) ? STAGGER_CYCLES : SETTLE_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ST_END = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] SE_END = CW'(SETTLE_CYCLES - 1);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "%m: illegal WIDTH=%0d (legal 1..32)", WIDTH);
  end
  if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > 255) begin : g_bad_stagger
    $fatal(1, "%m: illegal STAGGER_CYCLES=%0d (legal 1..255)", STAGGER_CYCLES);
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 1023) begin : g_bad_settle
    $fatal(1, "%m: illegal SETTLE_CYCLES=%0d (legal 1..1023)", SETTLE_CYCLES);
  end
  typedef enum logic [1:0] {OFF, STAGGER, SETTLE, ON} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] en_nx, en_grow, sync1, sync2;
  logic ready_nx, busy_nx, st_done, se_done, last;
  assign st_done = cnt == ST_END;
  assign se_done = cnt == SE_END;
  assign en_grow = BUF_EN | (BUF_EN << 1);
  assign last    = &en_grow;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= OFF;
      cnt    <= '0;
      BUF_EN <= '0;
      READY  <= 1'b0;
      BUSY   <= 1'b0;
      sync1  <= '0;
      sync2  <= '0;
      DATA   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      BUF_EN <= en_nx;
      READY  <= ready_nx;
      BUSY   <= busy_nx;
      sync1  <= BUF_O;
      sync2  <= sync1;
      DATA   <= READY ? sync2 : '0;
    end
  end
  // A dropped request returns straight to OFF from anywhere; no staggered power-down.
  always_comb begin
    state_nx = OFF;
    cnt_nx   = '0;
    if (ENABLE_REQ)
      case (state)
        OFF: state_nx = (WIDTH == 1) ? SETTLE : STAGGER;
        STAGGER: begin
          cnt_nx   = st_done ? '0 : cnt + CW'(1);
          state_nx = (st_done && last) ? SETTLE : STAGGER;
        end
        SETTLE: begin
          cnt_nx   = se_done ? '0 : cnt + CW'(1);
          state_nx = se_done ? ON : SETTLE;
        end
        default: state_nx = ON;
      endcase
  end
  always_comb begin
    en_nx    = '0;
    ready_nx = 1'b0;
    busy_nx  = 1'b0;
    if (ENABLE_REQ)
      case (state)
        OFF: begin
          en_nx   = WIDTH'(1);
          busy_nx = 1'b1;
        end
        STAGGER: begin
          en_nx   = st_done ? en_grow : BUF_EN;
          busy_nx = 1'b1;
        end
        SETTLE: begin
          en_nx    = BUF_EN;
          ready_nx = se_done;
          busy_nx  = !se_done;
        end
        default: begin
          en_nx    = BUF_EN;
          ready_nx = 1'b1;
        end
      endcase
  end
endmodule
